// File: rtl/skinny_sbox8_isw1_byte_seq.sv
// Byte-serial sequencer for an external first-order ISW SKINNY sbox8: one fresh mask per byte,
// sbox inputs held for LAT cycles, each result rotated into the MSB of its share register.
module skinny_sbox8_isw1_byte_seq #(
  parameter int unsigned LAT    = 8,
  parameter int unsigned NBYTES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_s0,
  input  logic [8*NBYTES-1:0] in_s1,
  input  logic                rnd_valid,
  output logic                rnd_ready,
  input  logic [15:0]         rnd,
  output logic [7:0]          sb_si0,
  output logic [7:0]          sb_si1,
  output logic [15:0]         sb_r,
  input  logic [7:0]          sb_bo0,
  input  logic [7:0]          sb_bo1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_s0,
  output logic [8*NBYTES-1:0] out_s1
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned CntW = $clog2(LAT) + 1;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StEval, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    st0_q, st1_q;
  logic [IdxW-1:0] idx_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      si0_q, si1_q;
  logic [15:0]     r_q;
  logic            in_ready_q, out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      st0_q       <= '0;
      st1_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      si0_q       <= '0;
      si1_q       <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            st0_q      <= in_s0;
            st1_q      <= in_s1;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          // Inputs stay zero while stalled so the sbox never sees a byte without its mask.
          if (rnd_valid) begin
            r_q     <= rnd;
            si0_q   <= st0_q[7:0];
            si1_q   <= st1_q[7:0];
            cnt_q   <= '0;
            state_q <= StEval;
          end
        end
        StEval: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(LAT - 1)) begin
            st0_q <= {sb_bo0, st0_q[W-1:8]};
            st1_q <= {sb_bo1, st1_q[W-1:8]};
            si0_q <= '0;
            si1_q <= '0;
            r_q   <= '0;
            idx_q <= idx_q + 1'b1;
            if (idx_q == IdxW'(NBYTES - 1)) begin
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            st0_q       <= '0;
            st1_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign rnd_ready = (state_q == StFetch);
  assign sb_si0    = si0_q;
  assign sb_si1    = si1_q;
  assign sb_r      = r_q;
  assign out_valid = out_valid_q;
  // Gate the share registers so a partially substituted state is never visible.
  assign out_s0    = out_valid_q ? st0_q : '0;
  assign out_s1    = out_valid_q ? st1_q : '0;

endmodule

// File: tb/tb_skinny_sbox8_isw1_byte_seq.sv
// Bench for skinny_sbox8_isw1_byte_seq: behavioural masked sbox plus a byte-level reference of
// the SKINNY 8-bit sbox applied to the unmasked state.
`timescale 1ns/1ps
module tb_skinny_sbox8_isw1_byte_seq;

  localparam int LAT = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_s0 = '0;
  logic [127:0] in_s1 = '0;
  logic         rnd_valid = 1'b0;
  logic         rnd_ready;
  logic [15:0]  rnd = '0;
  logic [7:0]   sb_si0, sb_si1;
  logic [15:0]  sb_r;
  logic [7:0]   sb_bo0, sb_bo1;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_s0, out_s1;

  int vec  = 0;
  int fail = 0;

  skinny_sbox8_isw1_byte_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_s0    (in_s0),
    .in_s1    (in_s1),
    .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready),
    .rnd      (rnd),
    .sb_si0   (sb_si0),
    .sb_si1   (sb_si1),
    .sb_r     (sb_r),
    .sb_bo0   (sb_bo0),
    .sb_bo1   (sb_bo1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s0   (out_s0),
    .out_s1   (out_s1)
  );

  always #5 clk = ~clk;

  // SKINNY-128 sbox: NOR/XOR layer and bit permutation, four rounds, last ends with a 1<->2 swap.
  function automatic logic [7:0] s8(input logic [7:0] xin);
    logic [7:0] x;
    x = xin;
    for (int i = 0; i < 4; i++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (i < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
    end
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  function automatic logic [127:0] rand128();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i+:32] = $urandom;
    return v;
  endfunction

  function automatic logic [15:0] fresh(input logic [15:0] old);
    logic [15:0] v;
    v = 16'($urandom);
    while (v == old) v = 16'($urandom);
    return v;
  endfunction

  // Masked sbox model: outputs are only correct once inputs have been stable for LAT cycles.
  logic [31:0] sb_prev = '0;
  int          sb_stab = 0;
  always @(negedge clk) begin
    logic [7:0] m;
    if ({sb_si0, sb_si1, sb_r} == sb_prev) sb_stab++;
    else sb_stab = 0;
    sb_prev = {sb_si0, sb_si1, sb_r};
    m = sb_r[7:0] ^ sb_r[15:8];
    if (sb_stab >= LAT - 1) begin
      sb_bo0 = s8(sb_si0 ^ sb_si1) ^ m;
      sb_bo1 = m;
    end else begin
      sb_bo0 = s8(sb_si0 ^ sb_si1) ^ m ^ 8'h5A;
      sb_bo1 = m ^ 8'hC3;
    end
  end

  task automatic run_one(input logic [127:0] a, input logic [127:0] b, input int stall_byte,
                         input int stall_len, input int out_wait, input int abort_byte,
                         output logic [127:0] o0, output logic [127:0] o1, output bit ok);
    logic [15:0]  used[$];
    logic [31:0]  tup0;
    logic [15:0]  prev_r;
    logic [127:0] exp0, exp1, snap0, snap1;
    logic [7:0]   m;
    int           lat, run, nb, stalled;
    bit           ev, take;
    ok = 1'b0; o0 = '0; o1 = '0;
    lat = 0; run = 0; nb = 0; stalled = 0; prev_r = '0; tup0 = '0;
    vec++;
    if (in_ready !== 1'b1) begin
      fail++; $display("FAIL accept_ready: got %b want 1", in_ready);
    end
    in_s0 = a; in_s1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (1) begin
      ev = !in_ready && !rnd_ready && !out_valid;
      if (!ev && run != 0) begin
        vec++;
        if (run != LAT) begin
          fail++; $display("FAIL eval_window byte %0d: got %0d want %0d cycles", nb, run, LAT);
        end
        nb++; run = 0;
      end
      if (out_valid || lat >= 400) break;
      if (rnd_ready) begin
        vec++;
        if ({sb_si0, sb_si1, sb_r} !== 32'h0) begin
          fail++; $display("FAIL fetch_inputs_zero: got %h want 0", {sb_si0, sb_si1, sb_r});
        end
        rnd_valid = !(nb == stall_byte && stalled < stall_len);
        if (!rnd_valid) stalled++;
      end else if (ev) begin
        if (run == 0) begin
          vec++;
          if (used.size() != nb + 1 || sb_si0 !== a[8*nb+:8] || sb_si1 !== b[8*nb+:8] ||
              sb_r !== used[nb]) begin
            fail++;
            $display("FAIL sbox_inputs byte %0d: got %h %h %h want %h %h %h", nb, sb_si0,
                     sb_si1, sb_r, a[8*nb+:8], b[8*nb+:8], used[nb]);
          end
          if (nb > 0) begin
            vec++;
            if (sb_r === prev_r) begin
              fail++; $display("FAIL mask_fresh byte %0d: got %h want new word", nb, sb_r);
            end
          end
          prev_r = sb_r;
          tup0 = {sb_si0, sb_si1, sb_r};
        end else begin
          vec++;
          if ({sb_si0, sb_si1, sb_r} !== tup0) begin
            fail++; $display("FAIL eval_hold byte %0d: got %h want %h", nb,
                             {sb_si0, sb_si1, sb_r}, tup0);
          end
        end
        run++;
        if (nb == abort_byte && run == 3) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          vec++;
          if (in_ready !== 1'b1 || out_valid !== 1'b0 || rnd_ready !== 1'b0 ||
              {sb_si0, sb_si1, sb_r} !== 32'h0 || out_s0 !== '0 || out_s1 !== '0) begin
            fail++;
            $display("FAIL abort_idle: got rdy=%b ov=%b rr=%b sb=%h want 1 0 0 0", in_ready,
                     out_valid, rnd_ready, {sb_si0, sb_si1, sb_r});
          end
          return;
        end
      end
      take = rnd_ready && rnd_valid;
      @(posedge clk); #1;
      lat++;
      if (take) begin
        used.push_back(rnd);
        rnd = fresh(rnd);
      end
    end
    vec++;
    if (lat != 144 + stall_len) begin
      fail++; $display("FAIL latency: got %0d want %0d", lat, 144 + stall_len);
    end
    if (!out_valid) return;
    vec++;
    if (used.size() != 16) begin
      fail++; $display("FAIL mask_count: got %0d want 16", used.size());
      return;
    end
    for (int k = 0; k < 16; k++) begin
      m = used[k][7:0] ^ used[k][15:8];
      exp1[8*k+:8] = m;
      exp0[8*k+:8] = s8(a[8*k+:8] ^ b[8*k+:8]) ^ m;
    end
    snap0 = out_s0; snap1 = out_s1;
    for (int w = 0; w < out_wait; w++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_s0 = rand128();
      @(posedge clk); #1;
      vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_s0 !== snap0 || out_s1 !== snap1) begin
        fail++; $display("FAIL out_hold cycle %0d: got ov=%b rdy=%b s0=%h want 1 0 %h", w,
                         out_valid, in_ready, out_s0, snap0);
      end
    end
    in_valid = 1'b0;
    vec++;
    if (out_s0 !== exp0) begin
      fail++; $display("FAIL out_s0: got %h want %h", out_s0, exp0);
    end
    vec++;
    if (out_s1 !== exp1) begin
      fail++; $display("FAIL out_s1: got %h want %h", out_s1, exp1);
    end
    o0 = out_s0; o1 = out_s1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_s0 !== '0 || out_s1 !== '0) begin
      fail++; $display("FAIL handshake_idle: got rdy=%b ov=%b s0=%h want 1 0 0", in_ready,
                       out_valid, out_s0);
    end
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rnd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || rnd_ready !== 1'b0) begin
      fail++; $display("FAIL reset_flags: got rdy=%b ov=%b rr=%b want 1 0 0", in_ready,
                       out_valid, rnd_ready);
    end
    vec++;
    if ({sb_si0, sb_si1, sb_r} !== 32'h0) begin
      fail++; $display("FAIL reset_sbox: got %h want 0", {sb_si0, sb_si1, sb_r});
    end
    vec++;
    if (out_s0 !== '0 || out_s1 !== '0) begin
      fail++; $display("FAIL reset_out: got %h %h want 0", out_s0, out_s1);
    end
    rst = 1'b0;
    rnd_valid = 1'b1;
    @(posedge clk); #1;
    vec++;
    if (in_ready !== 1'b1 || rnd_ready !== 1'b0) begin
      fail++; $display("FAIL idle_after_reset: got rdy=%b rr=%b want 1 0", in_ready, rnd_ready);
    end
  endtask

  task automatic test_zero_state();
    logic [127:0] o0, o1;
    bit ok;
    run_one('0, '0, -1, 0, 0, -1, o0, o1, ok);
    if (ok) begin
      vec++;
      if ((o0 ^ o1) !== {16{8'h65}}) begin
        fail++; $display("FAIL zero_unmasked: got %h want 6565..65", o0 ^ o1);
      end
    end
  endtask

  task automatic test_masked_ones();
    logic [127:0] mm, o0, o1;
    bit ok;
    mm = rand128();
    run_one(mm, ~mm, -1, 0, 0, -1, o0, o1, ok);
    if (ok) begin
      vec++;
      if ((o0 ^ o1) !== {128{1'b1}}) begin
        fail++; $display("FAIL ones_unmasked: got %h want ff..ff", o0 ^ o1);
      end
    end
  endtask

  task automatic test_rnd_stall();
    logic [127:0] o0, o1;
    bit ok;
    run_one(rand128(), rand128(), 3, 5, 0, -1, o0, o1, ok);
  endtask

  task automatic test_backpressure();
    logic [127:0] o0, o1;
    bit ok;
    run_one(rand128(), rand128(), -1, 0, 10, -1, o0, o1, ok);
  endtask

  task automatic test_reset_mid();
    logic [127:0] o0, o1;
    bit ok;
    run_one(rand128(), rand128(), -1, 0, 0, 7, o0, o1, ok);
    run_one(rand128(), rand128(), -1, 0, 0, -1, o0, o1, ok);
  endtask

  task automatic test_back_to_back();
    logic [127:0] o0, o1;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      run_one(rand128(), rand128(), $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 2), -1, o0, o1, ok);
    end
  endtask

  initial begin
    rnd = 16'($urandom);
    test_reset();
    test_zero_state();
    test_masked_ones();
    test_rnd_stall();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/skinny_sbox8_isw1_byte_seq.md
Name: skinny_sbox8_isw1_byte_seq

Overview:
Sequencer that drives the single non-pipelined first-order ISW sbox8 (two shares, 16-bit refresh mask, LAT-cycle evaluation) across the 16 bytes of a masked 128-bit SKINNY state. It accepts a two-share state and consumes one fresh 16-bit mask word per byte. It holds the sbox inputs and mask stable for the full evaluation window and writes each result back in place. It then presents the substituted two-share state to the round logic.

Parameters:
LAT, 8, sbox evaluation cycles with inputs held stable
NBYTES, 16, bytes per state

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  state shares valid
in_ready  out  1  block can accept a state
in_s0  in  128  state share 0
in_s1  in  128  state share 1
rnd_valid  in  1  fresh mask word available
rnd_ready  out  1  mask word consumed this cycle
rnd  in  16  fresh refresh mask
sb_si0  out  8  sbox input share 0
sb_si1  out  8  sbox input share 1
sb_r  out  16  sbox refresh mask
sb_bo0  in  8  sbox output share 0
sb_bo1  in  8  sbox output share 1
out_valid  out  1  substituted state valid
out_ready  in  1  consumer accepts state
out_s0  out  128  result share 0
out_s1  out  128  result share 1

Behaviour:
- Single clock. Reset is synchronous and active-high. rst dominates every other input.
- On reset: state=IDLE; byte idx=0; cycle cnt=0; st0/st1 regs=0; sb_si0/sb_si1/sb_r regs=0; in_ready=1, rnd_ready=0, out_valid=0, out_s0/out_s1=0.
- IDLE: in_ready=1. When in_valid=1, load st0<=in_s0, st1<=in_s1, set idx=0, go FETCH.
- FETCH: rnd_ready=1 combinationally, only in this state.
  - rnd_valid=0: stall, sbox input regs stay 0.
  - rnd_valid=1: mask accepted. sb_r<=rnd, sb_si0<=st0[7:0], sb_si1<=st1[7:0], cnt<=0, go EVAL.
  - Each mask word is used for exactly one byte and is never reused.
- EVAL: sb_si0, sb_si1 and sb_r are held constant, and cnt increments each cycle. At the edge where cnt==LAT-1:
  - capture st0<={sb_bo0, st0[127:8]} and st1<={sb_bo1, st1[127:8]} (rotate right by one byte, result inserted at MSB);
  - clear sb_si0/sb_si1/sb_r to 0; idx<=idx+1;
  - if idx==NBYTES-1 go DONE, else go FETCH.
- Byte order: bits[7:0] are processed first. After 16 rotations every byte is back in its original position.
- DONE: out_valid=1, out_s0=st0, out_s1=st1. Outputs hold until out_ready=1; at that edge go IDLE, clear st0/st1, out_valid=0.
- in_ready=0 outside IDLE. in_valid is ignored while busy.
- Shares are never combined: no share-0/share-1 XOR exists anywhere in the block. Mask bits go only to sb_r.
- Latency with rnd_valid held high: accept edge T0, FETCH at T0+1, capture of byte k at T0+9(k+1). out_valid rises after edge T0+144. Each FETCH stall adds one cycle per stalled cycle.
- Reset mid-operation: state aborts immediately to reset values. A partial state is never output, and the mask in flight is discarded.
- idx is 4 bits and wraps only through the DONE transition. cnt is log2(LAT)+1 bits and saturates nothing.

Test Plan:
- Reset then idle: rst high 2 cycles -> in_ready=1, out_valid=0, all sb_* outputs and out_s*=0.
- Zero state: in_s0=in_s1=0, rnd=random with rnd_valid=1 -> out_valid after 144 cycles; out_s0^out_s1 = 128'h6565…65 (S8(0x00)=0x65 per byte).
- Masked all-ones: in_s0=random M, in_s1=~M, rnd random -> out_s0^out_s1 = all 0xFF.
  - Also check that sb_si0/sb_si1/sb_r stay constant for exactly 8 cycles per byte.
  - Check that sb_r changes for every byte.
- Randomness stall: drop rnd_valid for 5 cycles before byte 3 -> rnd_ready high throughout, sb_si* stay 0, total latency 149, result unchanged.
- Output backpressure: out_ready=0 for 10 cycles -> out_valid and out_s* hold. in_valid pulses during the wait are ignored. After the out_ready=1 edge: in_ready=1 and out_valid=0.
- Reset mid-byte: assert rst in EVAL of byte 7 -> next cycle IDLE, out_valid=0. A fresh input then completes correctly with no residue from the aborted run.
